epp_bus_bridge: RTL and testbench

EPP slave that sits directly downstream of the FPGA top's EPP/USB data pins and converts Digilent EPP host cycles into single-beat transactions on the internal register bus inside digital_top. The EPP strobes and data are asynchronous to CLK, so they are synchronised first. The bridge then runs the EPP WAIT handshake, holds an 8-bit address register, and masters one request/acknowledge bus cycle per EPP data cycle. A timeout guards against a bus target that never acknowledges.

---
 rtl/epp_bus_bridge.sv | 199 +++++++++++++++++++
 tb/tb_epp_bus_bridge.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/epp_bus_bridge.sv
// ---------------------------------------------------------------------------
// epp_bus_bridge
//   Digilent EPP slave -> internal single-beat register bus master.
//   EPP strobes and WRITE are asynchronous to CLK and pass through
//   SYNC_STAGES-deep synchronisers. The FSM runs the WAIT handshake, keeps an
//   8-bit address register and issues one REQ/ACK bus cycle per EPP data
//   cycle, with a timeout guarding against a target that never acknowledges.
//
//   Optional build macro: EPP_ADDR_AUTOINC_EN
//     defined   -> address register increments (mod 256) after every data
//                  cycle, on ACK or timeout.
//     undefined -> address changes only on EPP address writes.
//
// Ports
//   CLK, RST_ASYNC           core clock, asynchronous active-high reset
//   EPP_ASTB_IN/DSTB_IN      EPP strobes, active low, asynchronous
//   EPP_WRITE_IN             EPP direction, low = host write, asynchronous
//   EPP_DATA_IN/OUT/OE_OUT   EPP data pad in / out / output enable
//   EPP_WAIT_OUT             EPP WAIT, high = cycle complete
//   BUS_REQ/WR/ADDR/WR_DATA  bus request side (valid while REQ)
//   BUS_ACK_IN/RD_DATA_IN    single-cycle acknowledge + read data
//   BUS_ERR_OUT              sticky timeout flag (cleared by address write)
// ---------------------------------------------------------------------------

// Single-bit multi-flop synchroniser with a selectable reset level.
module epp_bus_bridge_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic CLK,
  input  logic RST_ASYNC,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] ff;

  always_ff @(posedge CLK or posedge RST_ASYNC) begin
    if (RST_ASYNC) ff <= {STAGES{RST_VAL}};
    else           ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];
endmodule

module epp_bus_bridge #(
  parameter int         SYNC_STAGES = 2,
  parameter int         TIMEOUT_CYC = 255,
  parameter logic [7:0] ERR_RD_DATA = 8'hEE
) (
  input  logic       CLK,
  input  logic       RST_ASYNC,
  input  logic       EPP_ASTB_IN,
  input  logic       EPP_DSTB_IN,
  input  logic       EPP_WRITE_IN,
  input  logic [7:0] EPP_DATA_IN,
  output logic [7:0] EPP_DATA_OUT,
  output logic       EPP_DATA_OE_OUT,
  output logic       EPP_WAIT_OUT,
  output logic       BUS_REQ_OUT,
  output logic       BUS_WR_OUT,
  output logic [7:0] BUS_ADDR_OUT,
  output logic [7:0] BUS_WR_DATA_OUT,
  input  logic       BUS_ACK_IN,
  input  logic [7:0] BUS_RD_DATA_IN,
  output logic       BUS_ERR_OUT
);

`ifdef EPP_ADDR_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  // Counter value on the last cycle REQ may stay high without ACK.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

  localparam int NSYNC = 3;

  typedef enum logic [1:0] {IDLE, ADDR, DREQ, HOLD} state_t;

  // -------------------------------------------------------------------------
  // Synchronisers: bit 0 ASTB, bit 1 DSTB, bit 2 WRITE. All reset high,
  // which is the idle level of every one of them.
  // -------------------------------------------------------------------------
  logic [NSYNC-1:0] sync_raw, sync_q;
  assign sync_raw = {EPP_WRITE_IN, EPP_DSTB_IN, EPP_ASTB_IN};

  for (genvar i = 0; i < NSYNC; i++) begin : g_sync
    epp_bus_bridge_sync #(
      .STAGES  (SYNC_STAGES),
      .RST_VAL (1'b1)
    ) u_sync (
      .CLK       (CLK),
      .RST_ASYNC (RST_ASYNC),
      .d         (sync_raw[i]),
      .q         (sync_q[i])
    );
  end

  logic astb_s, dstb_s, write_s;
  assign astb_s  = sync_q[0];
  assign dstb_s  = sync_q[1];
  assign write_s = sync_q[2];

  // -------------------------------------------------------------------------
  // FSM and registered outputs
  // -------------------------------------------------------------------------
  state_t     state;
  logic       addr_is_wr;  // direction of the current address cycle
  logic [7:0] din_q;       // pad data captured on IDLE exit (address cycles)
  logic [7:0] addr_q;
  logic [7:0] to_cnt;

  assign BUS_ADDR_OUT = addr_q;

  always_ff @(posedge CLK or posedge RST_ASYNC) begin
    if (RST_ASYNC) begin
      state           <= IDLE;
      addr_is_wr      <= 1'b0;
      din_q           <= 8'h00;
      addr_q          <= 8'h00;
      to_cnt          <= 8'h00;
      EPP_DATA_OUT    <= 8'h00;
      EPP_DATA_OE_OUT <= 1'b0;
      EPP_WAIT_OUT    <= 1'b0;
      BUS_REQ_OUT     <= 1'b0;
      BUS_WR_OUT      <= 1'b0;
      BUS_WR_DATA_OUT <= 8'h00;
      BUS_ERR_OUT     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Address strobe wins a tie; DSTB then stays ignored because HOLD
          // only exits once both strobes are back high.
          if (!astb_s) begin
            state      <= ADDR;
            addr_is_wr <= !write_s;
            din_q      <= EPP_DATA_IN;
          end else if (!dstb_s) begin
            state           <= DREQ;
            BUS_REQ_OUT     <= 1'b1;
            BUS_WR_OUT      <= !write_s;
            BUS_WR_DATA_OUT <= EPP_DATA_IN;
            to_cnt          <= 8'h00;
          end
        end

        ADDR: begin
          if (addr_is_wr) begin
            addr_q      <= din_q;
            BUS_ERR_OUT <= 1'b0;
          end else begin
            EPP_DATA_OUT    <= addr_q;
            EPP_DATA_OE_OUT <= 1'b1;
          end
          EPP_WAIT_OUT <= 1'b1;
          state        <= HOLD;
        end

        DREQ: begin
          // ACK is checked first so an ACK on the terminal count is a success.
          if (BUS_ACK_IN) begin
            BUS_REQ_OUT  <= 1'b0;
            EPP_WAIT_OUT <= 1'b1;
            state        <= HOLD;
            if (!BUS_WR_OUT) begin
              EPP_DATA_OUT    <= BUS_RD_DATA_IN;
              EPP_DATA_OE_OUT <= 1'b1;
            end
            if (AUTOINC) addr_q <= addr_q + 8'd1;
          end else if (to_cnt == TO_LAST) begin
            BUS_REQ_OUT  <= 1'b0;
            BUS_ERR_OUT  <= 1'b1;
            EPP_WAIT_OUT <= 1'b1;
            state        <= HOLD;
            if (!BUS_WR_OUT) begin
              EPP_DATA_OUT    <= ERR_RD_DATA;
              EPP_DATA_OE_OUT <= 1'b1;
            end
            if (AUTOINC) addr_q <= addr_q + 8'd1;
          end else begin
            to_cnt <= to_cnt + 8'd1;
          end
        end

        HOLD: begin
          if (astb_s && dstb_s) begin
            EPP_WAIT_OUT    <= 1'b0;
            EPP_DATA_OE_OUT <= 1'b0;
            state           <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_epp_bus_bridge.sv
// ---------------------------------------------------------------------------
// tb_epp_bus_bridge
//   Directed + randomised EPP host cycles against a behavioural model of the
//   bridge (address register, sticky error, last read value, expected
//   latencies derived from the strobe-to-WAIT timing rules).
// ---------------------------------------------------------------------------
module tb_epp_bus_bridge;
  localparam int         S   = 2;
  localparam int         TO  = 255;
  localparam logic [7:0] ERR = 8'hEE;

`ifdef EPP_ADDR_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       astb, dstb, wr_n;
  logic [7:0] din;
  logic [7:0] dout;
  logic       oe, wt, req, bwr, ack, berr;
  logic [7:0] baddr, bwdata, brd;

  int checks   = 0;
  int failures = 0;

  // model state
  logic [7:0] addr_m = 8'h00;
  logic       err_m  = 1'b0;
  logic [7:0] dout_m = 8'h00;

  always #5 clk = ~clk;

  epp_bus_bridge #(
    .SYNC_STAGES (S),
    .TIMEOUT_CYC (TO),
    .ERR_RD_DATA (ERR)
  ) dut (
    .CLK             (clk),
    .RST_ASYNC       (rst),
    .EPP_ASTB_IN     (astb),
    .EPP_DSTB_IN     (dstb),
    .EPP_WRITE_IN    (wr_n),
    .EPP_DATA_IN     (din),
    .EPP_DATA_OUT    (dout),
    .EPP_DATA_OE_OUT (oe),
    .EPP_WAIT_OUT    (wt),
    .BUS_REQ_OUT     (req),
    .BUS_WR_OUT      (bwr),
    .BUS_ADDR_OUT    (baddr),
    .BUS_WR_DATA_OUT (bwdata),
    .BUS_ACK_IN      (ack),
    .BUS_RD_DATA_IN  (brd),
    .BUS_ERR_OUT     (berr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Release both strobes; WAIT must fall SYNC_STAGES+1 clocks later with OE.
  task automatic release_strobes(input string tag);
    int lat;
    lat = 0;
    @(negedge clk);
    astb = 1'b1;
    dstb = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (!wt) begin lat = k; break; end
    end
    chk({tag, "_wait_fall_lat"}, lat, S + 1);
    chk({tag, "_oe_idle"}, oe, 1'b0);
  endtask

  task automatic addr_cycle(input string tag, input bit write, input logic [7:0] data);
    int lat;
    bit saw_req;
    lat = 0;
    saw_req = 1'b0;
    @(negedge clk);
    wr_n = !write;
    din  = data;
    @(negedge clk);
    astb = 1'b0;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (req) saw_req = 1'b1;
      if (wt) begin lat = k; break; end
    end
    chk({tag, "_wait_rise_lat"}, lat, S + 2);
    chk({tag, "_no_req"}, saw_req, 1'b0);
    if (write) begin
      addr_m = data;
      err_m  = 1'b0;
      chk({tag, "_bus_addr"}, baddr, addr_m);
      chk({tag, "_err_clr"}, berr, err_m);
    end else begin
      dout_m = addr_m;
      chk({tag, "_oe"}, oe, 1'b1);
      chk({tag, "_rd_addr"}, dout, dout_m);
    end
    release_strobes(tag);
  endtask

  // dly < 0 : target never acknowledges. Otherwise ACK is seen after REQ
  // has been high for dly+1 cycles.
  task automatic data_cycle(input string tag, input bit write, input logic [7:0] wdata,
                            input int dly, input logic [7:0] rdata, input bit do_release);
    int lat, req_cnt, width;
    bit acked, timed_out;
    lat = 0; req_cnt = 0; acked = 1'b0;
    timed_out = (dly < 0) || (dly + 1 > TO);
    width     = timed_out ? TO : dly + 1;
    @(negedge clk);
    wr_n = !write;
    din  = wdata;
    @(negedge clk);
    dstb = 1'b0;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      if (req) begin
        req_cnt++;
        if (req_cnt == 1) begin
          chk({tag, "_bus_wr"}, bwr, write);
          chk({tag, "_bus_addr"}, baddr, addr_m);
          if (write) chk({tag, "_bus_wdata"}, bwdata, wdata);
        end
      end
      ack = 1'b0;
      brd = 8'($urandom);
      if (wt) begin lat = k; break; end
      if (dly >= 0 && req && !acked && req_cnt == dly + 1) begin
        ack   = 1'b1;
        brd   = rdata;
        acked = 1'b1;
      end
    end
    chk({tag, "_req_width"}, req_cnt, width);
    chk({tag, "_wait_rise_lat"}, lat, S + 1 + width);
    chk({tag, "_req_low"}, req, 1'b0);
    if (timed_out) err_m = 1'b1;
    if (!write) begin
      dout_m = timed_out ? ERR : rdata;
      chk({tag, "_oe"}, oe, 1'b1);
      chk({tag, "_rdata"}, dout, dout_m);
    end
    chk({tag, "_err"}, berr, err_m);
    if (AUTOINC) addr_m = addr_m + 8'd1;
    chk({tag, "_addr_after"}, baddr, addr_m);
    if (do_release) release_strobes(tag);
  endtask

  initial begin
    rst = 1'b1; astb = 1'b1; dstb = 1'b1; wr_n = 1'b1;
    din = 8'h00; ack = 1'b0; brd = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_wait", wt, 1'b0);
    chk("rst_oe", oe, 1'b0);
    chk("rst_dout", dout, 8'h00);
    chk("rst_req", req, 1'b0);
    chk("rst_bwr", bwr, 1'b0);
    chk("rst_baddr", baddr, 8'h00);
    chk("rst_bwdata", bwdata, 8'h00);
    chk("rst_err", berr, 1'b0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // address write / read
    addr_cycle("aw5a", 1'b1, 8'h5A);
    addr_cycle("ar5a", 1'b0, 8'h00);

    // data write, ACK after REQ has been high 3 cycles -> 4-cycle REQ
    data_cycle("dw3c", 1'b1, 8'h3C, 3, 8'h00, 1'b1);
    // data read with ACK data
    data_cycle("dra7", 1'b0, 8'h00, 1, 8'hA7, 1'b1);

    // stray ACK while idle must change nothing
    @(negedge clk); ack = 1'b1; brd = 8'h11;
    @(negedge clk); ack = 1'b0;
    repeat (2) @(negedge clk);
    chk("stray_req", req, 1'b0);
    chk("stray_wait", wt, 1'b0);
    chk("stray_dout", dout, dout_m);
    chk("stray_addr", baddr, addr_m);

    // ACK on the terminal count is a success
    data_cycle("dr_term", 1'b0, 8'h00, TO - 1, 8'h5C, 1'b1);

    // timeout read, then address write clears the error
    data_cycle("dr_to", 1'b0, 8'h00, -1, 8'h00, 1'b1);
    addr_cycle("aw_clr", 1'b1, 8'h21);

    // both strobes together: address cycle, no bus request
    begin
      int lat;
      bit saw_req;
      lat = 0; saw_req = 1'b0;
      @(negedge clk); wr_n = 1'b0; din = 8'h77;
      @(negedge clk); astb = 1'b0; dstb = 1'b0;
      for (int k = 1; k <= 50; k++) begin
        @(negedge clk);
        if (req) saw_req = 1'b1;
        if (wt) begin lat = k; break; end
      end
      addr_m = 8'h77; err_m = 1'b0;
      chk("both_lat", lat, S + 2);
      chk("both_addr", baddr, addr_m);
      release_strobes("both");
      repeat (4) begin
        @(negedge clk);
        if (req) saw_req = 1'b1;
      end
      chk("both_no_req", saw_req, 1'b0);
    end

    // reset during DREQ
    begin
      int n;
      n = 0;
      @(negedge clk); wr_n = 1'b1;
      @(negedge clk); dstb = 1'b0;
      for (int k = 1; k <= 50; k++) begin
        @(negedge clk);
        if (req) n++;
        if (n == 4) break;
      end
      chk("rdreq_req_before", req, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk("rdreq_req", req, 1'b0);
      chk("rdreq_wait", wt, 1'b0);
      chk("rdreq_oe", oe, 1'b0);
      dstb = 1'b1;
      @(negedge clk); rst = 1'b0;
      addr_m = 8'h00; err_m = 1'b0; dout_m = 8'h00;
      chk("rdreq_addr", baddr, addr_m);
      repeat (2) @(negedge clk);
    end

    // reset during HOLD of a read: pad released asynchronously
    data_cycle("rhold", 1'b0, 8'h00, 2, 8'h96, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("rhold_oe", oe, 1'b0);
    chk("rhold_wait", wt, 1'b0);
    dstb = 1'b1;
    @(negedge clk); rst = 1'b0;
    addr_m = 8'h00; err_m = 1'b0; dout_m = 8'h00;
    repeat (2) @(negedge clk);

    // address wrap sequence (increments only with the auto-increment build)
    addr_cycle("awfe", 1'b1, 8'hFE);
    for (int i = 0; i < 3; i++)
      data_cycle("wrap", 1'b1, 8'(8'h10 + i), int'($urandom_range(0, 4)), 8'h00, 1'b1);
    chk("wrap_final", baddr, AUTOINC ? 8'h01 : 8'hFE);

    // randomised host traffic
    for (int i = 0; i < 30; i++) begin
      int op;
      op = int'($urandom_range(0, 3));
      case (op)
        0: addr_cycle("rnd_aw", 1'b1, 8'($urandom));
        1: addr_cycle("rnd_ar", 1'b0, 8'($urandom));
        2: data_cycle("rnd_dw", 1'b1, 8'($urandom), int'($urandom_range(0, 6)), 8'h00, 1'b1);
        default: data_cycle("rnd_dr", 1'b0, 8'($urandom), int'($urandom_range(0, 6)), 8'($urandom), 1'b1);
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
